// File: rtl/rotary_encoder_controller.sv
// Rotary encoder front end: synchronises and hold-off-debounces A/B/switch, decodes
// full quadrature detents into CW/CCW step pulses and tracks a bounded position.
module rotary_encoder_controller #(
  parameter int unsigned HOLDOFF   = 20_000,
  parameter int unsigned POS_WIDTH = 8,
  parameter int unsigned POS_MAX   = 255,
  parameter int unsigned POS_INIT  = 0,
  parameter int unsigned WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 encA,
  input  logic                 encB,
  input  logic                 encSw,
  input  logic                 posClear,
  output logic                 stepCw,
  output logic                 stepCcw,
  output logic                 seqError,
  output logic                 btnPress,
  output logic                 btnLevel,
  output logic [POS_WIDTH-1:0] position
);

  localparam int unsigned NCH   = 3;
  localparam int unsigned CNT_W = $clog2(HOLDOFF + 1);
  // Channel order {A, B, switch}: A and B idle high, the switch idles low.
  localparam logic [NCH-1:0]       IDLE_LVL = 3'b110;
  localparam logic [CNT_W-1:0]     HOLD_LD  = CNT_W'(HOLDOFF);
  localparam logic [POS_WIDTH-1:0] P_MAX    = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] P_INIT   = POS_WIDTH'(POS_INIT);

  typedef enum logic [2:0] {
    ST_DETENT, ST_CW1, ST_CW2, ST_CW3, ST_CCW1, ST_CCW2, ST_CCW3, ST_RESYNC
  } state_e;

  logic [NCH-1:0]       sync1_q, sync2_q, filt_q, filt_d;
  logic [CNT_W-1:0]     cnt_q [NCH];
  logic [CNT_W-1:0]     cnt_d [NCH];
  logic [1:0]           ab_c, ab_prev_q;
  logic                 illegal_c;
  state_e               state_q, state_d;
  logic                 step_cw_q, step_cw_d, step_ccw_q, step_ccw_d;
  logic                 seq_err_q, seq_err_d, btn_press_q, btn_press_d, sw_dly_q;
  logic [POS_WIDTH-1:0] pos_q, pos_d;

  // Hold-off filter: accept a change only when the channel's counter has run out.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else if (sync2_q[i] != filt_q[i]) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = HOLD_LD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      filt_q  <= IDLE_LVL;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {encA, encB, encSw};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign ab_c      = filt_q[2:1];
  assign illegal_c = (ab_c ^ ab_prev_q) == 2'b11;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DETENT;
      ab_prev_q <= 2'b11;
    end else begin
      state_q   <= state_d;
      ab_prev_q <= ab_c;
    end
  end

  // Quadrature next state; any single-bit change not listed for a state holds it.
  always_comb begin
    state_d = state_q;
    if (illegal_c) begin
      state_d = (ab_c == 2'b11) ? ST_DETENT : ST_RESYNC;
    end else begin
      unique case (state_q)
        ST_DETENT: if (ab_c == 2'b01) state_d = ST_CW1;
                   else if (ab_c == 2'b10) state_d = ST_CCW1;
        ST_CW1:    if (ab_c == 2'b00) state_d = ST_CW2;
                   else if (ab_c == 2'b11) state_d = ST_DETENT;
        ST_CW2:    if (ab_c == 2'b10) state_d = ST_CW3;
                   else if (ab_c == 2'b01) state_d = ST_CW1;
        ST_CW3:    if (ab_c == 2'b11) state_d = ST_DETENT;
                   else if (ab_c == 2'b00) state_d = ST_CW2;
        ST_CCW1:   if (ab_c == 2'b00) state_d = ST_CCW2;
                   else if (ab_c == 2'b11) state_d = ST_DETENT;
        ST_CCW2:   if (ab_c == 2'b01) state_d = ST_CCW3;
                   else if (ab_c == 2'b10) state_d = ST_CCW1;
        ST_CCW3:   if (ab_c == 2'b11) state_d = ST_DETENT;
                   else if (ab_c == 2'b00) state_d = ST_CCW2;
        ST_RESYNC: if (ab_c == 2'b11) state_d = ST_DETENT;
        default:   state_d = ST_RESYNC;
      endcase
    end
  end

  // Pulse and position next values; position moves on the same edge the pulse rises.
  always_comb begin
    step_cw_d   = !illegal_c && (state_q == ST_CW3) && (ab_c == 2'b11);
    step_ccw_d  = !illegal_c && (state_q == ST_CCW3) && (ab_c == 2'b11);
    seq_err_d   = illegal_c;
    btn_press_d = filt_q[0] && !sw_dly_q;
    pos_d       = pos_q;
    if (posClear) begin
      pos_d = P_INIT;
    end else if (step_cw_d) begin
      if (pos_q == P_MAX) pos_d = (WRAP != 0) ? '0 : P_MAX;
      else                pos_d = pos_q + POS_WIDTH'(1);
    end else if (step_ccw_d) begin
      if (pos_q == '0) pos_d = (WRAP != 0) ? P_MAX : '0;
      else             pos_d = pos_q - POS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cw_q   <= 1'b0;
      step_ccw_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      btn_press_q <= 1'b0;
      sw_dly_q    <= 1'b0;
      pos_q       <= P_INIT;
    end else begin
      step_cw_q   <= step_cw_d;
      step_ccw_q  <= step_ccw_d;
      seq_err_q   <= seq_err_d;
      btn_press_q <= btn_press_d;
      sw_dly_q    <= filt_q[0];
      pos_q       <= pos_d;
    end
  end

  assign stepCw   = step_cw_q;
  assign stepCcw  = step_ccw_q;
  assign seqError = seq_err_q;
  assign btnPress = btn_press_q;
  assign btnLevel = filt_q[0];
  assign position = pos_q;

endmodule

// File: tb/tb_rotary_encoder_controller.sv
// Bench for rotary_encoder_controller: a wrapping 8-bit instance and a saturating
// 0..9 instance share stimulus and are checked against a detent-phase model.
module tb_rotary_encoder_controller;

  localparam int unsigned HO = 4;
  localparam int SAT_MAX = 9;

  logic clk, rst_n, enc_a, enc_b, enc_sw, pos_clear;
  logic cw_w, ccw_w, err_w, press_w, lvl_w;
  logic cw_s, ccw_s, err_s, press_s, lvl_s;
  logic [7:0] pos_w, pos_s;

  rotary_encoder_controller #(.HOLDOFF(HO), .POS_WIDTH(8), .POS_MAX(255), .POS_INIT(0), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .encA(enc_a), .encB(enc_b), .encSw(enc_sw), .posClear(pos_clear),
    .stepCw(cw_w), .stepCcw(ccw_w), .seqError(err_w), .btnPress(press_w), .btnLevel(lvl_w),
    .position(pos_w));

  rotary_encoder_controller #(.HOLDOFF(HO), .POS_WIDTH(8), .POS_MAX(SAT_MAX), .POS_INIT(0), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .encA(enc_a), .encB(enc_b), .encSw(enc_sw), .posClear(pos_clear),
    .stepCw(cw_s), .stepCcw(ccw_s), .seqError(err_s), .btnPress(press_s), .btnLevel(lvl_s),
    .position(pos_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed pulse counts (cycles high), accumulated over the whole run.
  int n_cw_w = 0, n_ccw_w = 0, n_err_w = 0, n_press_w = 0, n_both_w = 0;
  int n_cw_s = 0, n_ccw_s = 0, n_err_s = 0, n_press_s = 0, n_both_s = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_cw_w += int'(cw_w);  n_ccw_w += int'(ccw_w);  n_err_w += int'(err_w);
      n_press_w += int'(press_w); n_both_w += int'(cw_w & ccw_w);
      n_cw_s += int'(cw_s);  n_ccw_s += int'(ccw_s);  n_err_s += int'(err_s);
      n_press_s += int'(press_s); n_both_s += int'(cw_s & ccw_s);
    end
  end

  // Reference model: signed quarter-cycle count since the last detent.
  logic [1:0] m_ab = 2'b11;
  int  m_sum = 0;
  bit  m_lost = 1'b0;
  int  exp_cw = 0, exp_ccw = 0, exp_err = 0, exp_press = 0;
  int  exp_pos_w = 0, exp_pos_s = 0;

  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int ph);
    case (ph % 4)
      0:       return 2'b11;
      1:       return 2'b01;
      2:       return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_ab(input logic [1:0] ab);
    int d;
    if (ab == m_ab) return;
    if ((ab ^ m_ab) == 2'b11) begin
      exp_err++;
      m_lost = (ab != 2'b11);
      m_sum = 0;
    end else if (m_lost) begin
      if (ab == 2'b11) m_lost = 1'b0;
      m_sum = 0;
    end else begin
      d = (phase(ab) - phase(m_ab) + 4) % 4;
      m_sum += (d == 1) ? 1 : -1;
      if (ab == 2'b11) begin
        if (m_sum == 4) begin
          exp_cw++;
          exp_pos_w = (exp_pos_w == 255) ? 0 : exp_pos_w + 1;
          exp_pos_s = (exp_pos_s == SAT_MAX) ? SAT_MAX : exp_pos_s + 1;
        end else if (m_sum == -4) begin
          exp_ccw++;
          exp_pos_w = (exp_pos_w == 0) ? 255 : exp_pos_w - 1;
          exp_pos_s = (exp_pos_s == 0) ? 0 : exp_pos_s - 1;
        end
        m_sum = 0;
      end
    end
    m_ab = ab;
  endtask

  task automatic model_reset();
    m_ab = 2'b11; m_sum = 0; m_lost = 1'b0; exp_pos_w = 0; exp_pos_s = 0;
  endtask

  task automatic drive_ab(input logic [1:0] ab, input int hold);
    @(negedge clk);
    enc_a = ab[1];
    enc_b = ab[0];
    model_ab(ab);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b0; pos_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b0; pos_clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cw_w, ccw_w, err_w, press_w, lvl_w, cw_s, ccw_s, err_s, press_s, lvl_s} !== 10'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 0", {cw_w, ccw_w, err_w, press_w, lvl_w, cw_s, ccw_s, err_s, press_s, lvl_s});
    end
    checks++;
    if (pos_w !== 8'd0 || pos_s !== 8'd0) begin
      errors++;
      $display("FAIL reset_position: got %0d/%0d want 0/0", pos_w, pos_s);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cw();
    foreach (m_ab[i]) ;
    drive_ab(2'b01, 10); drive_ab(2'b00, 10); drive_ab(2'b10, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_cw_w !== exp_cw || n_cw_s !== exp_cw || n_ccw_w !== exp_ccw) begin
      errors++;
      $display("FAIL cw_steps: got cw %0d/%0d ccw %0d want cw %0d ccw %0d", n_cw_w, n_cw_s, n_ccw_w, exp_cw, exp_ccw);
    end
    checks++;
    if (pos_w !== 8'(exp_pos_w) || pos_s !== 8'(exp_pos_s)) begin
      errors++;
      $display("FAIL cw_position: got %0d/%0d want %0d/%0d", pos_w, pos_s, exp_pos_w, exp_pos_s);
    end
    checks++;
    if (n_err_w !== exp_err || n_err_s !== exp_err) begin
      errors++;
      $display("FAIL cw_seqerr: got %0d/%0d want %0d", n_err_w, n_err_s, exp_err);
    end
  endtask

  task automatic test_ccw_wrap();
    do_reset();
    drive_ab(2'b10, 10); drive_ab(2'b00, 10); drive_ab(2'b01, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_ccw_w !== exp_ccw || n_ccw_s !== exp_ccw) begin
      errors++;
      $display("FAIL ccw_steps: got %0d/%0d want %0d", n_ccw_w, n_ccw_s, exp_ccw);
    end
    checks++;
    if (pos_w !== 8'd255 || pos_s !== 8'd0) begin
      errors++;
      $display("FAIL ccw_bottom_bound: got %0d/%0d want 255/0", pos_w, pos_s);
    end
    drive_ab(2'b01, 10); drive_ab(2'b00, 10); drive_ab(2'b10, 10); drive_ab(2'b11, 10);
    checks++;
    if (pos_w !== 8'd0 || pos_s !== 8'd1 || n_cw_w !== exp_cw) begin
      errors++;
      $display("FAIL cw_top_wrap: got %0d/%0d cw %0d want 0/1 cw %0d", pos_w, pos_s, n_cw_w, exp_cw);
    end
  endtask

  task automatic test_bounce();
    int cw0, ccw0, err0;
    cw0 = n_cw_w; ccw0 = n_ccw_w; err0 = n_err_w;
    @(negedge clk) enc_a = 1'b0;
    @(negedge clk) enc_a = 1'b1;
    @(negedge clk) enc_a = 1'b0;
    model_ab(2'b01);
    repeat (12) @(negedge clk);
    checks++;
    if (n_cw_w !== cw0 || n_ccw_w !== ccw0 || n_err_w !== err0) begin
      errors++;
      $display("FAIL bounce_quiet: got cw %0d ccw %0d err %0d want %0d %0d %0d", n_cw_w, n_ccw_w, n_err_w, cw0, ccw0, err0);
    end
    drive_ab(2'b00, 10); drive_ab(2'b10, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_cw_w !== exp_cw || n_err_w !== exp_err || pos_w !== 8'(exp_pos_w)) begin
      errors++;
      $display("FAIL bounce_then_cw: got cw %0d err %0d pos %0d want %0d %0d %0d", n_cw_w, n_err_w, pos_w, exp_cw, exp_err, exp_pos_w);
    end
  endtask

  task automatic test_reversal();
    int cw0, ccw0, err0, p0;
    cw0 = n_cw_w; ccw0 = n_ccw_w; err0 = n_err_w; p0 = int'(pos_w);
    drive_ab(2'b01, 10); drive_ab(2'b00, 10); drive_ab(2'b01, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_cw_w !== cw0 || n_ccw_w !== ccw0 || n_err_w !== err0 || int'(pos_w) !== p0) begin
      errors++;
      $display("FAIL reversal: got cw %0d ccw %0d err %0d pos %0d want %0d %0d %0d %0d", n_cw_w, n_ccw_w, n_err_w, pos_w, cw0, ccw0, err0, p0);
    end
  endtask

  task automatic test_illegal();
    int cw0;
    cw0 = n_cw_w;
    drive_ab(2'b00, 10);
    checks++;
    if (n_err_w !== exp_err || n_err_s !== exp_err) begin
      errors++;
      $display("FAIL illegal_seqerr: got %0d/%0d want %0d", n_err_w, n_err_s, exp_err);
    end
    drive_ab(2'b10, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_cw_w !== cw0 || n_ccw_w !== exp_ccw || n_err_w !== exp_err) begin
      errors++;
      $display("FAIL resync_no_step: got cw %0d ccw %0d err %0d want %0d %0d %0d", n_cw_w, n_ccw_w, n_err_w, cw0, exp_ccw, exp_err);
    end
    drive_ab(2'b01, 10); drive_ab(2'b00, 10); drive_ab(2'b10, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_cw_w !== cw0 + 1 || pos_w !== 8'(exp_pos_w)) begin
      errors++;
      $display("FAIL resync_then_cw: got cw %0d pos %0d want %0d %0d", n_cw_w, pos_w, cw0 + 1, exp_pos_w);
    end
  endtask

  task automatic test_clear_coincident();
    @(negedge clk) pos_clear = 1'b1;
    @(negedge clk) pos_clear = 1'b0;
    exp_pos_w = 0; exp_pos_s = 0;
    for (int k = 0; k < 5; k++) begin
      drive_ab(2'b01, 9); drive_ab(2'b00, 9); drive_ab(2'b10, 9); drive_ab(2'b11, 9);
    end
    checks++;
    if (pos_w !== 8'd5 || pos_s !== 8'd5) begin
      errors++;
      $display("FAIL clear_preload: got %0d/%0d want 5/5", pos_w, pos_s);
    end
    drive_ab(2'b01, 9); drive_ab(2'b00, 9); drive_ab(2'b10, 9);
    @(negedge clk);
    enc_a = 1'b1; enc_b = 1'b1; pos_clear = 1'b1;
    model_ab(2'b11);
    exp_pos_w = 0; exp_pos_s = 0;
    repeat (6) @(negedge clk);
    pos_clear = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (pos_w !== 8'd0 || pos_s !== 8'd0 || n_cw_w !== exp_cw || n_cw_s !== exp_cw) begin
      errors++;
      $display("FAIL clear_with_step: got pos %0d/%0d cw %0d/%0d want 0/0 cw %0d", pos_w, pos_s, n_cw_w, n_cw_s, exp_cw);
    end
  endtask

  task automatic test_switch();
    @(negedge clk) enc_sw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lvl_w !== 1'b0 || lvl_s !== 1'b0) begin
      errors++;
      $display("FAIL sw_latency_early: got %b/%b want 0", lvl_w, lvl_s);
    end
    @(posedge clk); #1;
    checks++;
    if (lvl_w !== 1'b1 || press_w !== 1'b0) begin
      errors++;
      $display("FAIL sw_latency_level: got lvl %b press %b want 1 0", lvl_w, press_w);
    end
    @(posedge clk); #1;
    checks++;
    if (press_w !== 1'b1 || press_s !== 1'b1) begin
      errors++;
      $display("FAIL sw_press_pulse: got %b/%b want 1", press_w, press_s);
    end
    @(posedge clk); #1;
    checks++;
    if (press_w !== 1'b0) begin
      errors++;
      $display("FAIL sw_press_width: got %b want 0", press_w);
    end
    exp_press++;
    repeat (16) @(negedge clk);
    checks++;
    if (n_press_w !== exp_press || n_press_s !== exp_press || lvl_w !== 1'b1) begin
      errors++;
      $display("FAIL sw_hold: got press %0d/%0d lvl %b want %0d 1", n_press_w, n_press_s, lvl_w, exp_press);
    end
    enc_sw = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (n_press_w !== exp_press || lvl_w !== 1'b0) begin
      errors++;
      $display("FAIL sw_release: got press %0d lvl %b want %0d 0", n_press_w, lvl_w, exp_press);
    end
  endtask

  task automatic test_random();
    int kind, ph, depth, hold;
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(8, 12));
      ph = phase(m_ab);
      if (kind <= 4) begin
        for (int s = 1; s <= 4; s++) drive_ab(ab_of(ph + s), hold);
      end else if (kind <= 6) begin
        for (int s = 1; s <= 4; s++) drive_ab(ab_of(ph + 4 - s), hold);
      end else if (kind == 7) begin
        depth = int'($urandom_range(1, 3));
        for (int s = 1; s <= depth; s++) drive_ab(ab_of(ph + s), hold);
        for (int s = depth - 1; s >= 0; s--) drive_ab(ab_of(ph + s), hold);
      end else if (kind == 8) begin
        drive_ab(m_ab ^ 2'b11, hold);
      end else begin
        drive_ab(ab_of(ph + (($urandom_range(0, 1) == 1) ? 1 : 3)), hold);
      end
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk) pos_clear = 1'b1;
        @(negedge clk) pos_clear = 1'b0;
        exp_pos_w = 0; exp_pos_s = 0;
      end
      if (it % 10 == 9) begin
        checks++;
        if (n_cw_w !== exp_cw || n_ccw_w !== exp_ccw || n_err_w !== exp_err ||
            n_cw_s !== exp_cw || n_ccw_s !== exp_ccw || n_err_s !== exp_err) begin
          errors++;
          $display("FAIL random_counts it%0d: got cw %0d/%0d ccw %0d/%0d err %0d/%0d want %0d %0d %0d",
                   it, n_cw_w, n_cw_s, n_ccw_w, n_ccw_s, n_err_w, n_err_s, exp_cw, exp_ccw, exp_err);
        end
        checks++;
        if (pos_w !== 8'(exp_pos_w) || pos_s !== 8'(exp_pos_s)) begin
          errors++;
          $display("FAIL random_position it%0d: got %0d/%0d want %0d/%0d", it, pos_w, pos_s, exp_pos_w, exp_pos_s);
        end
      end
    end
    checks++;
    if (n_both_w !== 0 || n_both_s !== 0) begin
      errors++;
      $display("FAIL step_exclusive: got %0d/%0d overlap cycles want 0", n_both_w, n_both_s);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk) enc_sw = 1'b1;
    repeat (10) @(negedge clk);
    exp_press++;
    drive_ab(ab_of(phase(m_ab) + 1), 10);
    drive_ab(2'b11, 10);
    drive_ab(2'b01, 10); drive_ab(2'b00, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pos_w !== 8'd0 || pos_s !== 8'd0 || lvl_w !== 1'b0 || lvl_s !== 1'b0 ||
        {cw_w, ccw_w, err_w, press_w} !== 4'b0) begin
      errors++;
      $display("FAIL reset_async: got pos %0d/%0d lvl %b/%b pulses %b want 0/0 0/0 0000",
               pos_w, pos_s, lvl_w, lvl_s, {cw_w, ccw_w, err_w, press_w});
    end
    enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (n_cw_w !== exp_cw || n_ccw_w !== exp_ccw || n_err_w !== exp_err || n_press_w !== exp_press) begin
      errors++;
      $display("FAIL reset_discard: got cw %0d ccw %0d err %0d press %0d want %0d %0d %0d %0d",
               n_cw_w, n_ccw_w, n_err_w, n_press_w, exp_cw, exp_ccw, exp_err, exp_press);
    end
    drive_ab(2'b01, 10); drive_ab(2'b00, 10); drive_ab(2'b10, 10); drive_ab(2'b11, 10);
    checks++;
    if (n_cw_w !== exp_cw || pos_w !== 8'd1 || pos_s !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_cw: got cw %0d pos %0d/%0d want %0d 1/1", n_cw_w, pos_w, pos_s, exp_cw);
    end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw_wrap();
    test_bounce();
    test_reversal();
    test_illegal();
    test_clear_coincident();
    test_switch();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
